// File: rtl/pipe_ctrl_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Merges the load-use stall, the data-memory wait, the iterative mul/div
// wait and branch redirects into per-register write enables and flushes.
// It also owns a memory-timeout watchdog and a saturating stall counter.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   load_use_stall                 ID/EX load-use hazard (combinational)
//   branch_taken_ex                redirect from EX this cycle
//   dmem_req / dmem_ready          MEM-stage data memory handshake
//   md_start / md_done             EX-stage mul/div handshake
//   pc_we, *_we                    PC and pipeline register write enables
//   *_flush                        load bubble/NOP into pipeline register
//   mem_timeout                    one-cycle watchdog pulse
//   mem_err                        sticky watchdog flag
//   stall_cycles                   saturating count of cycles with pc_we=0
//   state_o                        FSM state (debug)
//
// state     | meaning
// ----------+-----------------------------------------------
// RUN       | no multi-cycle resource outstanding
// MEM_WAIT  | data memory access outstanding, watchdog armed
// MD_WAIT   | mul/div operation outstanding

module pipe_ctrl_sequencer #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_use_stall,
   input  logic             branch_taken_ex,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             md_start,
   input  logic             md_done,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             id_ex_we,
   output logic             ex_mem_we,
   output logic             mem_wb_we,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             mem_wb_flush,
   output logic             mem_timeout,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [1:0]       state_o
);

   localparam int WD_W = $clog2(MEM_TIMEOUT);
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_MD_WAIT  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic       wd_fire;
   logic       mem_miss_run;
   logic       md_miss_run;
   logic       mem_hold;
   logic       md_hold;
   logic [4:0] we_c;   // {pc, if_id, id_ex, ex_mem, mem_wb}
   logic [3:0] fl_c;   // {if_id, id_ex, ex_mem, mem_wb}

   always_comb begin
      wd_fire      = (state_q == ST_MEM_WAIT) && !dmem_ready && (wd_cnt_q == WD_LAST);
      mem_miss_run = (state_q == ST_RUN) && dmem_req && !dmem_ready;
      md_miss_run  = (state_q == ST_RUN) && md_start && !md_done;
      // The watchdog cycle counts as completion, so it releases the freeze.
      mem_hold     = ((state_q == ST_MEM_WAIT) && !dmem_ready && !wd_fire) || mem_miss_run;
      md_hold      = ((state_q == ST_MD_WAIT) && !md_done) || md_miss_run;

      we_c = 5'b11111;
      fl_c = 4'b0000;
      if (mem_hold) begin
         we_c = 5'b00000;
         fl_c = 4'b0001;
      end else if (md_hold) begin
         we_c = 5'b00011;
         fl_c = 4'b0010;
      end else if (branch_taken_ex) begin
         // Branch wins over load-use: the dependent instruction is squashed.
         fl_c = 4'b1100;
      end else if (load_use_stall) begin
         we_c = 5'b00111;
         fl_c = 4'b0100;
      end

      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (mem_miss_run)
               state_d = ST_MEM_WAIT;
            else if (md_miss_run)
               state_d = ST_MD_WAIT;
         end
         ST_MEM_WAIT: begin
            if (dmem_ready || wd_fire)
               state_d = ST_RUN;
         end
         ST_MD_WAIT: begin
            if (md_done)
               state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase

      // Counter is zero on the first MEM_WAIT cycle and never exceeds
      // WD_LAST, since MEM_WAIT is always left by then.
      wd_cnt_d = (state_q == ST_MEM_WAIT) ? wd_cnt_q + 1'b1 : '0;

      mem_err_d = mem_err_q | wd_fire;

      stall_cnt_d = stall_cnt_q;
      if (!we_c[4] && (stall_cnt_q != CNT_MAX))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         wd_cnt_q    <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wd_cnt_q    <= wd_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Control outputs are forced low combinationally so an asserted reset
   // takes effect without waiting for a clock edge.
   assign pc_we        = rst_n & we_c[4];
   assign if_id_we     = rst_n & we_c[3];
   assign id_ex_we     = rst_n & we_c[2];
   assign ex_mem_we    = rst_n & we_c[1];
   assign mem_wb_we    = rst_n & we_c[0];
   assign if_id_flush  = rst_n & fl_c[3];
   assign id_ex_flush  = rst_n & fl_c[2];
   assign ex_mem_flush = rst_n & fl_c[1];
   assign mem_wb_flush = rst_n & fl_c[0];
   assign mem_timeout  = rst_n & wd_fire;
   assign mem_err      = mem_err_q;
   assign stall_cycles = stall_cnt_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_pipe_ctrl_sequencer.sv
module tb_pipe_ctrl_sequencer;

   localparam int CNT_W = 4;

   logic clk, rst_n;
   logic load_use_stall, branch_taken_ex, dmem_req, dmem_ready, md_start, md_done;
   logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
   logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   logic mem_timeout, mem_err;
   logic [CNT_W-1:0] stall_cycles;
   logic [1:0] state_o;

   int n_cmp = 0;
   int n_err = 0;

   pipe_ctrl_sequencer #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_use_stall(load_use_stall), .branch_taken_ex(branch_taken_ex),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .md_start(md_start), .md_done(md_done),
      .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
      .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
      .mem_timeout(mem_timeout), .mem_err(mem_err),
      .stall_cycles(stall_cycles), .state_o(state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [4:0] WE_ALL = 5'b11111, WE_MEM = 5'b00000, WE_MD = 5'b00011, WE_LU = 5'b00111;
   localparam logic [3:0] FL_NONE = 4'b0000, FL_MEM = 4'b0001, FL_MD = 4'b0010,
                          FL_BR = 4'b1100, FL_LU = 4'b0100;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pipe(input string tag, input logic [4:0] we, input logic [3:0] fl,
                           input logic [1:0] st);
      chk({tag, ".we"}, {27'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}, {27'd0, we});
      chk({tag, ".flush"}, {28'd0, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}, {28'd0, fl});
      chk({tag, ".state"}, {30'd0, state_o}, {30'd0, st});
   endtask

   task automatic chk_stall(input string tag, input int exp);
      chk({tag, ".stall"}, {{(32-CNT_W){1'b0}}, stall_cycles}, exp);
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic cyc(input logic lu, input logic br, input logic req, input logic rdy,
                      input logic ms, input logic md);
      @(negedge clk);
      load_use_stall  = lu;
      branch_taken_ex = br;
      dmem_req        = req;
      dmem_ready      = rdy;
      md_start        = ms;
      md_done         = md;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      load_use_stall = 0; branch_taken_ex = 0; dmem_req = 0;
      dmem_ready = 0; md_start = 0; md_done = 0;
      #2;
      chk_pipe("reset", WE_MEM, FL_NONE, 2'd0);
      chk("reset.mem_timeout", {31'd0, mem_timeout}, 0);
      chk("reset.mem_err", {31'd0, mem_err}, 0);
      chk_stall("reset", 0);

      @(negedge clk);
      rst_n = 1'b1;

      cyc(0, 0, 0, 0, 0, 0);
      chk_pipe("idle", WE_ALL, FL_NONE, 2'd0);

      cyc(1, 0, 0, 0, 0, 0);
      chk_pipe("load_use", WE_LU, FL_LU, 2'd0);
      chk_stall("load_use", 0);

      cyc(1, 1, 0, 0, 0, 0);
      chk_pipe("br_lu", WE_ALL, FL_BR, 2'd0);
      chk_stall("br_lu", 1);

      // memory wait: entry + three MEM_WAIT cycles held, ready on the fourth
      cyc(0, 0, 1, 0, 0, 0);
      chk_pipe("mem_entry", WE_MEM, FL_MEM, 2'd0);
      chk_stall("mem_entry", 1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 0, 0, 0);
         chk_pipe($sformatf("mem_wait%0d", i), WE_MEM, FL_MEM, 2'd1);
         chk("mem_wait.mem_timeout", {31'd0, mem_timeout}, 0);
      end
      cyc(0, 0, 1, 1, 0, 0);
      chk_pipe("mem_ready", WE_ALL, FL_NONE, 2'd1);
      chk("mem_ready.mem_timeout", {31'd0, mem_timeout}, 0);
      chk_stall("mem_ready", 5);
      cyc(0, 0, 0, 0, 0, 0);
      chk_pipe("mem_after", WE_ALL, FL_NONE, 2'd0);
      chk_stall("mem_after", 5);

      // mul/div with a branch held in EX: no redirect until md_done
      cyc(0, 1, 0, 0, 1, 0);
      chk_pipe("md_entry", WE_MD, FL_MD, 2'd0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 0, 0, 1, 0);
         chk_pipe($sformatf("md_wait%0d", i), WE_MD, FL_MD, 2'd2);
      end
      cyc(0, 1, 0, 0, 1, 1);
      chk_pipe("md_done_br", WE_ALL, FL_BR, 2'd2);
      chk_stall("md_done_br", 10);
      cyc(0, 0, 0, 0, 0, 0);
      chk_pipe("md_after", WE_ALL, FL_NONE, 2'd0);

      // memory and mul/div pending together: memory first, then mul/div
      cyc(0, 0, 1, 0, 1, 0);
      chk_pipe("both_entry", WE_MEM, FL_MEM, 2'd0);
      cyc(0, 0, 1, 1, 1, 0);
      chk_pipe("both_mem_ready", WE_ALL, FL_NONE, 2'd1);
      chk_stall("both_mem_ready", 11);
      cyc(0, 0, 0, 0, 1, 0);
      chk_pipe("both_md_entry", WE_MD, FL_MD, 2'd0);
      cyc(0, 0, 0, 0, 1, 1);
      chk_pipe("both_md_done", WE_ALL, FL_NONE, 2'd2);
      chk_stall("both_md_done", 12);

      // same-cycle ready/done in RUN: no stall, no state change
      cyc(0, 0, 1, 1, 1, 1);
      chk_pipe("same_cycle", WE_ALL, FL_NONE, 2'd0);
      cyc(0, 0, 0, 0, 0, 0);
      chk_pipe("same_after", WE_ALL, FL_NONE, 2'd0);
      chk_stall("same_after", 12);

      // watchdog with MEM_TIMEOUT=4; stall counter saturates at 15
      cyc(0, 0, 1, 0, 0, 0);
      chk_pipe("wd_entry", WE_MEM, FL_MEM, 2'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 0, 0, 0);
         chk_pipe($sformatf("wd_wait%0d", i), WE_MEM, FL_MEM, 2'd1);
         chk("wd_wait.mem_timeout", {31'd0, mem_timeout}, 0);
         chk_stall($sformatf("wd_wait%0d", i), 13 + i);
      end
      cyc(0, 0, 1, 0, 0, 0);
      chk_pipe("wd_fire", WE_ALL, FL_NONE, 2'd1);
      chk("wd_fire.mem_timeout", {31'd0, mem_timeout}, 1);
      chk("wd_fire.mem_err", {31'd0, mem_err}, 0);
      chk_stall("wd_fire_sat", 15);
      cyc(0, 0, 0, 0, 0, 0);
      chk_pipe("wd_after", WE_ALL, FL_NONE, 2'd0);
      chk("wd_after.mem_timeout", {31'd0, mem_timeout}, 0);
      chk("wd_after.mem_err", {31'd0, mem_err}, 1);
      chk_stall("wd_after", 15);
      cyc(1, 0, 0, 0, 0, 0);
      chk("wd_sticky.mem_err", {31'd0, mem_err}, 1);
      cyc(0, 0, 0, 0, 0, 0);
      chk_stall("sat_hold", 15);

      // asynchronous reset in the middle of MD_WAIT
      cyc(0, 0, 0, 0, 1, 0);
      chk_pipe("rst_md_entry", WE_MD, FL_MD, 2'd0);
      cyc(0, 0, 0, 0, 1, 0);
      chk_pipe("rst_md_wait", WE_MD, FL_MD, 2'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_pipe("async_rst", WE_MEM, FL_NONE, 2'd0);
      chk("async_rst.mem_err", {31'd0, mem_err}, 0);
      chk_stall("async_rst", 0);
      @(negedge clk);
      rst_n = 1'b1;
      md_start = 1'b0;
      #1;
      chk_pipe("rst_release", WE_ALL, FL_NONE, 2'd0);
      chk("rst_release.mem_err", {31'd0, mem_err}, 0);
      chk_stall("rst_release", 0);

      cyc(0, 1, 0, 0, 0, 0);
      chk_pipe("branch_only", WE_ALL, FL_BR, 2'd0);
      cyc(0, 0, 0, 0, 0, 0);
      chk_stall("branch_only", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
